// File: rtl/clock_pkg.sv
// Shared BCD types, modulus constants and the two-digit BCD increment helper
// used by the time-of-day counter.
package clock_pkg;

  typedef logic [3:0] bcdDigit_t;

  typedef struct packed {
    bcdDigit_t tens;
    bcdDigit_t units;
  } bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Next value of a two-digit BCD count that wraps to 00 after maxVal.
  function automatic bcd2_t bcdInc(bcd2_t v, bcd2_t maxVal);
    bcd2_t r;
    r = v;
    if (v == maxVal) begin
      r = '0;
    end else if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_counter_bcd_if.sv
// Signal bundle between the time-of-day core and its surroundings: the 1 Hz
// input, pause/adjust controls, and the BCD time, tick and chime outputs.
interface time_counter_bcd_if;
  import clock_pkg::*;

  logic  CLK_1HzIn;
  logic  PAUSE;
  logic  ADJ_MIN;
  logic  ADJ_HOUR;
  bcd2_t SEC;
  bcd2_t MIN;
  bcd2_t HOUR;
  logic  SEC_TICK;
  logic  CHIME;

  // Drives the controls and observes the time (divider / buttons / display).
  modport master (
    output CLK_1HzIn, PAUSE, ADJ_MIN, ADJ_HOUR,
    input  SEC, MIN, HOUR, SEC_TICK, CHIME
  );

  // The time-of-day core itself.
  modport slave (
    input  CLK_1HzIn, PAUSE, ADJ_MIN, ADJ_HOUR,
    output SEC, MIN, HOUR, SEC_TICK, CHIME
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX. carry is a combinational
// pulse asserted when inc arrives while the count sits at MAX, so the next
// stage can step on the same clock edge. clr takes priority over inc.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = SEC_MAX
) (
  input  logic  CLK_50M,
  input  logic  CLR,
  input  logic  inc,
  input  logic  clr,
  output bcd2_t count,
  output logic  carry
);

  assign carry = inc & (count == MAX);

  // Count register: asynchronous reset, synchronous clear, then increment.
  // NOTE: CLR is in the sensitivity list so reset takes effect without a clock edge.
  always_ff @(posedge CLK_50M or posedge CLR) begin
    if (CLR) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= bcdInc(count, MAX);
    end
  end

endmodule

// File: rtl/time_counter_bcd.sv
// 24-hour BCD time-of-day core. Turns each rising edge of the 1 Hz divider
// output into one second, chains SEC -> MIN -> HOUR carries, and applies
// minute/hour adjust pulses, which take priority over a same-cycle second.
// Optional hourly chime enabled by defining HOURLY_CHIME_EN.
module time_counter_bcd
  import clock_pkg::*;
#(
  parameter int CHIME_SECS = 5
) (
  input logic               CLK_50M,
  input logic               CLR,
  time_counter_bcd_if.slave bus
);

  logic prev;
  logic rise;
  logic tick;
  logic secCarry;
  logic minCarry;
  logic hourStep;
  logic unusedHourCarry;

  assign rise     = bus.CLK_1HzIn & ~prev;
  assign tick     = rise & ~bus.PAUSE & ~bus.ADJ_MIN & ~bus.ADJ_HOUR;
  // Only a counted second may carry into the hours; an ADJ_MIN wrap may not.
  assign hourStep = minCarry & tick;

  // Edge-detect history and the registered one-cycle second pulse.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge CLK_50M or posedge CLR) begin
    if (CLR) begin
      prev         <= 1'b0;
      bus.SEC_TICK <= 1'b0;
    end else begin
      prev         <= bus.CLK_1HzIn;
      bus.SEC_TICK <= tick;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .CLK_50M (CLK_50M),
    .CLR     (CLR),
    .inc     (tick),
    .clr     (bus.ADJ_MIN),
    .count   (bus.SEC),
    .carry   (secCarry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .CLK_50M (CLK_50M),
    .CLR     (CLR),
    .inc     (secCarry | bus.ADJ_MIN),
    .clr     (1'b0),
    .count   (bus.MIN),
    .carry   (minCarry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .CLK_50M (CLK_50M),
    .CLR     (CLR),
    .inc     (hourStep | bus.ADJ_HOUR),
    .clr     (1'b0),
    .count   (bus.HOUR),
    .carry   (unusedHourCarry)
  );

`ifdef HOURLY_CHIME_EN
  logic [5:0] chimeCnt;

  // Chime: an hour carry (re)loads the countdown; each later counted second
  // decrements it and CHIME drops on the second that reaches zero.
  always_ff @(posedge CLK_50M or posedge CLR) begin
    if (CLR) begin
      chimeCnt  <= '0;
      bus.CHIME <= 1'b0;
    end else if (hourStep) begin
      chimeCnt  <= CHIME_SECS[5:0];
      bus.CHIME <= 1'b1;
    end else if (tick && bus.CHIME) begin
      chimeCnt <= chimeCnt - 6'd1;
      if (chimeCnt == 6'd1) begin
        bus.CHIME <= 1'b0;
      end
    end
  end
`else
  localparam int unusedChimeSecs = CHIME_SECS;
  assign bus.CHIME = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter_bcd.sv
// Scoreboard bench for time_counter_bcd: every counted second pushes the
// expected time into a queue and a monitor pops it when SEC_TICK appears.
// Adjusts, pause and reset are checked directly against a decimal time model.
module tb_time_counter_bcd;
  import clock_pkg::*;

  localparam int ChimeSecs = 5;

  logic CLK_50M = 1'b0;
  logic CLR;

  time_counter_bcd_if bus ();

  time_counter_bcd #(.CHIME_SECS(ChimeSecs)) dut (
    .CLK_50M (CLK_50M),
    .CLR     (CLR),
    .bus     (bus)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       chime;
  } expect_t;

  expect_t expQ[$];
  int      assertCount = 0;
  int      failCount   = 0;
  int      tickCount   = 0;
  int      mH = 0, mM = 0, mS = 0;
  int      chimeLeft = 0;
  logic    chimeExp = 1'b0;

  function automatic logic [7:0] toBcd(int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic expect_t modelState();
    return {toBcd(mH), toBcd(mM), toBcd(mS), chimeExp};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkNow(string name);
    check(name, 32'({bus.HOUR, bus.MIN, bus.SEC, bus.CHIME}), 32'(modelState()));
  endtask

  // Advance the decimal model by one counted second and queue the result.
  task automatic modelTick();
    logic rolled;
    rolled = 1'b0;
    mS++;
    if (mS == 60) begin
      mS = 0;
      mM++;
      if (mM == 60) begin
        mM = 0;
        mH = (mH + 1) % 24;
        rolled = 1'b1;
      end
    end
`ifdef HOURLY_CHIME_EN
    if (rolled) begin
      chimeExp  = 1'b1;
      chimeLeft = ChimeSecs;
    end else if (chimeExp) begin
      chimeLeft--;
      if (chimeLeft == 0) chimeExp = 1'b0;
    end
`else
    if (rolled) chimeExp = 1'b0;
`endif
    expQ.push_back(modelState());
  endtask

  // One 1 Hz period: high for highCycles clocks, then low.
  task automatic second(int highCycles);
    @(negedge CLK_50M);
    bus.CLK_1HzIn = 1'b1;
    if (!bus.PAUSE) modelTick();
    repeat (highCycles) @(negedge CLK_50M);
    bus.CLK_1HzIn = 1'b0;
    @(negedge CLK_50M);
  endtask

  // One-cycle adjust pulse(s), optionally colliding with a 1 Hz rise.
  task automatic adjust(logic doMin, logic doHour, logic withRise);
    @(negedge CLK_50M);
    bus.ADJ_MIN  = doMin;
    bus.ADJ_HOUR = doHour;
    if (withRise) bus.CLK_1HzIn = 1'b1;
    if (doMin) begin
      mM = (mM + 1) % 60;
      mS = 0;
    end
    if (doHour) mH = (mH + 1) % 24;
    @(negedge CLK_50M);
    bus.ADJ_MIN   = 1'b0;
    bus.ADJ_HOUR  = 1'b0;
    bus.CLK_1HzIn = 1'b0;
  endtask

  // Monitor: every SEC_TICK cycle must match the next queued expectation.
  always @(negedge CLK_50M) begin : monitor
    expect_t e;
    if (CLR !== 1'b1 && bus.SEC_TICK === 1'b1) begin
      tickCount++;
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("FAIL unexpected SEC_TICK: got tick at %0h:%0h:%0h, expected none",
                 bus.HOUR, bus.MIN, bus.SEC);
      end else begin
        e = expQ.pop_front();
        check("tick state", 32'({bus.HOUR, bus.MIN, bus.SEC, bus.CHIME}), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0;
    CLR           = 1'b1;
    bus.CLK_1HzIn = 1'b0;
    bus.PAUSE     = 1'b0;
    bus.ADJ_MIN   = 1'b0;
    bus.ADJ_HOUR  = 1'b0;
    repeat (3) @(negedge CLK_50M);
    check("reset state", 32'({bus.HOUR, bus.MIN, bus.SEC, bus.SEC_TICK, bus.CHIME}), 32'h0);
    CLR = 1'b0;

    // Full minute of seconds.
    t0 = tickCount;
    repeat (60) second(1);
    check("60 ticks", 32'(tickCount - t0), 32'd60);
    checkNow("after 60 seconds");

    // Long high level gives one tick only.
    t0 = tickCount;
    second(1000);
    check("long high one tick", 32'(tickCount - t0), 32'd1);
    checkNow("after long high");

    // Rise while paused is lost.
    @(negedge CLK_50M);
    bus.PAUSE = 1'b1;
    t0 = tickCount;
    second(2);
    bus.PAUSE = 1'b0;
    @(negedge CLK_50M);
    check("paused rise no tick", 32'(tickCount - t0), 32'd0);
    checkNow("paused rise");

    // Preload to 23:59:00, then count up to 23:59:50 and across midnight.
    repeat (23) adjust(1'b0, 1'b1, 1'b0);
    repeat (58) adjust(1'b1, 1'b0, 1'b0);
    checkNow("preload 23:59:00");
    repeat (50) second(1);
    checkNow("preload 23:59:50");
    repeat (10) second(1);
    checkNow("midnight rollover");
    repeat (4) second(1);
    checkNow("chime after 4 seconds");
    second(1);
    checkNow("chime after 5 seconds");

    // ADJ_MIN at 10:59:30 wraps minutes without touching hours.
    repeat (10) adjust(1'b0, 1'b1, 1'b0);
    repeat (59) adjust(1'b1, 1'b0, 1'b0);
    repeat (30) second(1);
    checkNow("at 10:59:30");
    adjust(1'b1, 1'b0, 1'b0);
    checkNow("adj_min wrap");

    // ADJ_HOUR at 23:00:03 wraps hours and keeps MIN/SEC.
    repeat (13) adjust(1'b0, 1'b1, 1'b0);
    repeat (3) second(1);
    adjust(1'b0, 1'b1, 1'b0);
    checkNow("adj_hour wrap");

    // ADJ_MIN colliding with a rise at 00:00:07.
    repeat (4) second(1);
    checkNow("at 00:00:07");
    adjust(1'b1, 1'b0, 1'b1);
    check("collision SEC_TICK", 32'(bus.SEC_TICK), 32'd0);
    checkNow("adjust beats rise");

    // Both adjusts together at 00:59:00: no carry between them.
    repeat (58) adjust(1'b1, 1'b0, 1'b0);
    adjust(1'b1, 1'b1, 1'b0);
    checkNow("both adjusts");

    // Asynchronous clear mid-count at 12:34:56.
    repeat (11) adjust(1'b0, 1'b1, 1'b0);
    repeat (34) adjust(1'b1, 1'b0, 1'b0);
    repeat (56) second(1);
    checkNow("at 12:34:56");
    @(posedge CLK_50M);
    #5;
    CLR = 1'b1;
    #1;
    check("async clear", 32'({bus.HOUR, bus.MIN, bus.SEC, bus.SEC_TICK, bus.CHIME}), 32'h0);
    mH = 0; mM = 0; mS = 0; chimeExp = 1'b0; chimeLeft = 0;
    @(negedge CLK_50M);
    CLR = 1'b0;
    second(1);
    checkNow("resume after clear");

    repeat (3) @(negedge CLK_50M);
    check("queue drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/time_counter_bcd.md
# time_counter_bcd

Time-of-day core for the digital clock, directly downstream of the 50 MHz-to-1 Hz divider. It consumes the divider's 1 Hz square wave in the CLK_50M domain and converts each rising edge into one accepted second. It keeps a 24-hour BCD HH:MM:SS count and accepts minute/hour adjust pulses. Its BCD outputs feed the display/decoder stage.

## Interface
- CHIME_SECS, default 5: number of accepted seconds CHIME stays high after each hour rollover; legal range 1..59.
- CLK_50M  in  1  system clock, 50 MHz.
- CLR  in  1  asynchronous reset, active-high.
- CLK_1HzIn  in  1  1 Hz square wave from the divider; synchronous to CLK_50M.
- PAUSE  in  1  level; while high, 1 Hz edges are ignored.
- ADJ_MIN  in  1  one-cycle pulse; advance minutes.
- ADJ_HOUR  in  1  one-cycle pulse; advance hours.
- SEC  out  8  BCD seconds {tens[7:4], units[3:0]}, 00..59.
- MIN  out  8  BCD minutes, 00..59.
- HOUR  out  8  BCD hours, 00..23.
- SEC_TICK  out  1  one-cycle pulse on every accepted second.
- CHIME  out  1  hourly chime level.

## Operation
- Edge detect: register CLK_1HzIn into prev.
  - rise = CLK_1HzIn & ~prev.
  - tick = rise & ~PAUSE & ~ADJ_MIN & ~ADJ_HOUR.
- On tick, SEC increments with BCD carries:
  - units 9 -> 0 carries to tens.
  - SEC 59 -> 00 carries to MIN.
  - MIN 59 -> 00 carries to HOUR.
  - HOUR 23 -> 00 with no further carry.
- ADJ_MIN:
  - MIN increments; 59 -> 00 with no carry into HOUR.
  - SEC clears to 00.
  - Acts regardless of PAUSE.
- ADJ_HOUR:
  - HOUR increments; 23 -> 00.
  - MIN and SEC are unchanged.
  - Acts regardless of PAUSE.
- ADJ_MIN and ADJ_HOUR in the same cycle: both are applied, with no carry between them.
- Adjust and rise in the same cycle: adjust wins. The second is discarded and SEC_TICK stays low.
- SEC_TICK equals tick, registered.
- Counters only increment, so an illegal BCD code is unreachable. No load port exists.

## Timing
- All outputs are registered.
- Reset values: SEC = MIN = HOUR = 8'h00, SEC_TICK = 0, CHIME = 0, prev = 0, chime counter = 0.
- Latency:
  - CLK_1HzIn is first sampled high at edge k with prev = 0.
  - SEC/MIN/HOUR and SEC_TICK update at edge k.
  - SEC_TICK falls at k+1.
- An adjust pulse sampled at edge k is reflected at edge k.
- Exactly one tick per CLK_1HzIn rising edge, however long CLK_1HzIn stays high.
- PAUSE high during a rise loses that second; no catch-up after PAUSE falls.
- If CLK_1HzIn is high when CLR deasserts, the next edge sees prev = 0 and produces one tick. This is accepted behaviour, since the divider also resets its output to 0.
- CLR asserted mid-count forces all reset values immediately (asynchronous).

## Configuration
- HOURLY_CHIME_EN defined:
  - A tick that rolls MIN 59 -> 00 (hour carry) sets CHIME = 1 and loads the countdown with CHIME_SECS.
  - Each subsequent tick decrements the countdown; CHIME falls on the tick where it reaches 0.
  - PAUSE freezes the countdown.
  - ADJ_HOUR and ADJ_MIN never start a chime.
  - A new hour carry during an active chime reloads the countdown.
- HOURLY_CHIME_EN undefined: CHIME is tied to 0, and the countdown register and compare logic are absent.

## Structure
- Shared package clock_pkg holds:
  - BCD digit typedef (4-bit).
  - Two-digit BCD typedef (8-bit).
  - Constants SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23.
- One sub-module, bcd_mod_counter:
  - Two-digit BCD counter with inc, clr, and a MAX constant as parameter.
  - Outputs the count and a carry pulse (inc while at MAX).
  - Instantiated three times.
- Edge detect, adjust priority and chime live in the top.

## Test plan
- Reset then 60 rises on CLK_1HzIn -> SEC 00 -> 59 -> 00, MIN = 01, exactly 60 one-cycle SEC_TICK pulses.
- Preload via adjusts to 23:59:50, then 10 rises -> HOUR/MIN/SEC = 00:00:00. With HOURLY_CHIME_EN, CHIME goes high on that tick and falls after 5 further rises.
- CLK_1HzIn held high 1000 cycles -> one tick only. Rise while PAUSE = 1 -> SEC unchanged, SEC_TICK stays 0.
- At 10:59:30, ADJ_MIN -> 10:00:00 with HOUR unchanged. At 23:xx, ADJ_HOUR -> 00:xx with the same MIN/SEC.
- ADJ_MIN in the same cycle as a rise at 00:00:07 -> 00:01:00, SEC_TICK = 0.
- CLR pulsed mid-count at 12:34:56 -> all outputs 0 immediately, without waiting for a clock edge; counting resumes from 00:00:00 on the next rise.
